// File: rtl/iot_tty_controller_pkg.sv
// Shared definitions for the IOT teletype controller: device codes, IOT
// function codes and the print sequencer state type.
package iot_tty_controller_pkg;

    localparam logic [5:0] KB_DEV_DEFAULT = 6'o03;
    localparam logic [5:0] TP_DEV_DEFAULT = 6'o04;

    // Keyboard function codes (IR[2:0])
    localparam logic [2:0] FN_KCF = 3'd0;
    localparam logic [2:0] FN_KSF = 3'd1;
    localparam logic [2:0] FN_KCC = 3'd2;
    localparam logic [2:0] FN_KRS = 3'd4;
    localparam logic [2:0] FN_KIE = 3'd5;
    localparam logic [2:0] FN_KRB = 3'd6;

    // Printer function codes (IR[2:0])
    localparam logic [2:0] FN_TFL = 3'd0;
    localparam logic [2:0] FN_TSF = 3'd1;
    localparam logic [2:0] FN_TCF = 3'd2;
    localparam logic [2:0] FN_TPC = 3'd4;
    localparam logic [2:0] FN_TSK = 3'd5;
    localparam logic [2:0] FN_TLS = 3'd6;

    typedef enum logic [1:0] {
        PR_IDLE = 2'd0,
        PR_SEND = 2'd1,
        PR_DONE = 2'd2
    } pr_state_t;

endpackage

// File: rtl/iot_tty_printer.sv
// Print sequencer: offers one byte to the printer on start, holds it until tp_ready.
// Latency: tp_valid one cycle after start; done pulses the cycle after the handshake.
module iot_tty_printer
    import iot_tty_controller_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] byte_dat,
    output logic       tp_valid,
    output logic [7:0] tp_data,
    input  logic       tp_ready,
    output logic       done
);

    pr_state_t r_state;
    pr_state_t w_next;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= PR_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Outputs decode straight from state so reset drops tp_valid without a clock.
    always_comb begin
        w_next   = r_state;
        tp_valid = 1'b0;
        tp_data  = 8'h00;
        done     = 1'b0;
        case (r_state)
            PR_IDLE: begin
                if (start) begin
                    w_next = PR_SEND;
                end
            end
            PR_SEND: begin
                tp_valid = 1'b1;
                tp_data  = byte_dat;
                if (tp_ready) begin
                    w_next = PR_DONE;
                end
            end
            PR_DONE: begin
                done   = 1'b1;
                w_next = PR_IDLE;
            end
            default: begin
                w_next = PR_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/iot_tty_controller.sv
// Keyboard/teleprinter IOT device pair: decodes CPU IOT strobes, answers one cycle later.
// Keyboard uses kb_ready = !kb_flag; printer byte is held on tp_valid until tp_ready.
module iot_tty_controller
    import iot_tty_controller_pkg::*;
#(
    parameter logic [5:0] KB_DEV = KB_DEV_DEFAULT,
    parameter logic [5:0] TP_DEV = TP_DEV_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iot_req,
    input  logic [5:0] iot_dev,
    input  logic [2:0] iot_fn,
    input  logic [7:0] dataout,
    output logic [7:0] datain,
    output logic       skip,
    output logic       clr_ac,
    output logic       iot_ack,
    input  logic       kb_valid,
    input  logic [7:0] kb_data,
    output logic       kb_ready,
    output logic       tp_valid,
    output logic [7:0] tp_data,
    input  logic       tp_ready,
    output logic       int_req
);

    logic [7:0] r_kbuf;
    logic [7:0] r_tbuf;
    logic       r_kb_flag;
    logic       r_tp_flag;
    logic       r_int_en;
    logic       r_int_req;
    logic       r_ack;
    logic       r_skip;
    logic       r_clr_ac;
    logic [7:0] r_datain;

    logic       w_kb_hit;
    logic       w_tp_hit;
    logic       w_kb_accept;
    logic       w_kb_clr;
    logic       w_tp_set;
    logic       w_tp_clr;
    logic       w_start_req;
    logic       w_start;
    logic       w_int_en_ld;
    logic       w_skip;
    logic       w_clr_ac;
    logic [7:0] w_datain;
    logic       w_pr_valid;
    logic [7:0] w_pr_data;
    logic       w_pr_done;
    logic       w_pr_idle;

    assign w_kb_hit    = iot_req && (iot_dev == KB_DEV);
    assign w_tp_hit    = iot_req && (iot_dev == TP_DEV);
    assign w_kb_accept = kb_valid && !r_kb_flag;
    assign w_pr_idle   = !w_pr_valid && !w_pr_done;
    // A start while the sequencer is busy is acked but otherwise dropped.
    assign w_start     = w_start_req && w_pr_idle;

    always_comb begin
        w_kb_clr    = 1'b0;
        w_tp_set    = 1'b0;
        w_tp_clr    = 1'b0;
        w_start_req = 1'b0;
        w_int_en_ld = 1'b0;
        w_skip      = 1'b0;
        w_clr_ac    = 1'b0;
        w_datain    = 8'h00;
        if (w_kb_hit) begin
            case (iot_fn)
                FN_KCF: w_kb_clr = 1'b1;
                FN_KSF: w_skip   = r_kb_flag;
                FN_KCC: begin
                    w_kb_clr = 1'b1;
                    w_clr_ac = 1'b1;
                end
                FN_KRS: w_datain    = r_kbuf;
                FN_KIE: w_int_en_ld = 1'b1;
                FN_KRB: begin
                    w_kb_clr = 1'b1;
                    w_clr_ac = 1'b1;
                    w_datain = r_kbuf;
                end
                default: ;
            endcase
        end
        if (w_tp_hit) begin
            case (iot_fn)
                FN_TFL: w_tp_set    = 1'b1;
                FN_TSF: w_skip      = r_tp_flag;
                FN_TCF: w_tp_clr    = 1'b1;
                FN_TPC: w_start_req = 1'b1;
                FN_TSK: w_skip      = r_tp_flag || r_kb_flag;
                FN_TLS: begin
                    w_tp_clr    = 1'b1;
                    w_start_req = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // An accept only happens with the flag clear, so it always wins over a clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_kbuf    <= 8'h00;
            r_kb_flag <= 1'b0;
        end else if (w_kb_accept) begin
            r_kbuf    <= kb_data;
            r_kb_flag <= 1'b1;
        end else if (w_kb_clr) begin
            r_kb_flag <= 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_tp_flag <= 1'b0;
        end else if (w_pr_done || w_tp_set) begin
            r_tp_flag <= 1'b1;
        end else if (w_tp_clr) begin
            r_tp_flag <= 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_tbuf    <= 8'h00;
            r_int_en  <= 1'b0;
            r_int_req <= 1'b0;
        end else begin
            if (w_start) begin
                r_tbuf <= dataout;
            end
            if (w_int_en_ld) begin
                r_int_en <= dataout[0];
            end
            r_int_req <= r_int_en && (r_kb_flag || r_tp_flag);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ack    <= 1'b0;
            r_skip   <= 1'b0;
            r_clr_ac <= 1'b0;
            r_datain <= 8'h00;
        end else begin
            r_ack    <= w_kb_hit || w_tp_hit;
            r_skip   <= w_skip;
            r_clr_ac <= w_clr_ac;
            r_datain <= w_datain;
        end
    end

    iot_tty_printer u_printer (
        .clock    (clock),
        .reset    (reset),
        .start    (w_start),
        .byte_dat (r_tbuf),
        .tp_valid (w_pr_valid),
        .tp_data  (w_pr_data),
        .tp_ready (tp_ready),
        .done     (w_pr_done)
    );

    assign datain   = r_datain;
    assign skip     = r_skip;
    assign clr_ac   = r_clr_ac;
    assign iot_ack  = r_ack;
    assign kb_ready = !r_kb_flag;
    assign tp_valid = w_pr_valid;
    assign tp_data  = w_pr_data;
    assign int_req  = r_int_req;

endmodule

// File: tb/tb_iot_tty_controller.sv
// Directed scenarios plus randomized IOT/keyboard/printer traffic against a reference model.
module tb_iot_tty_controller;
    import iot_tty_controller_pkg::*;

    localparam logic [5:0] KB = 6'o03;
    localparam logic [5:0] TP = 6'o04;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       iot_req = 1'b0;
    logic [5:0] iot_dev = 6'd0;
    logic [2:0] iot_fn = 3'd0;
    logic [7:0] dataout = 8'h00;
    logic [7:0] datain;
    logic       skip;
    logic       clr_ac;
    logic       iot_ack;
    logic       kb_valid = 1'b0;
    logic [7:0] kb_data = 8'h00;
    logic       kb_ready;
    logic       tp_valid;
    logic [7:0] tp_data;
    logic       tp_ready = 1'b0;
    logic       int_req;

    always #5 clock = ~clock;

    iot_tty_controller dut (
        .clock    (clock),
        .reset    (reset),
        .iot_req  (iot_req),
        .iot_dev  (iot_dev),
        .iot_fn   (iot_fn),
        .dataout  (dataout),
        .datain   (datain),
        .skip     (skip),
        .clr_ac   (clr_ac),
        .iot_ack  (iot_ack),
        .kb_valid (kb_valid),
        .kb_data  (kb_data),
        .kb_ready (kb_ready),
        .tp_valid (tp_valid),
        .tp_data  (tp_data),
        .tp_ready (tp_ready),
        .int_req  (int_req)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_xfer  = 0;

    // Reference model: device registers plus "byte in flight" / "completion pending".
    logic [7:0] m_kbuf, m_tbuf, m_din;
    bit m_kbf, m_tpf, m_ie, m_irq, m_ack, m_skip, m_clr, m_sending, m_finishing;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_kbuf = 8'h00; m_tbuf = 8'h00; m_din = 8'h00;
        m_kbf = 0; m_tpf = 0; m_ie = 0; m_irq = 0;
        m_ack = 0; m_skip = 0; m_clr = 0; m_sending = 0; m_finishing = 0;
    endtask

    task automatic model_step();
        bit kb_hit, tp_hit, idle, start;
        bit n_kbf, n_tpf, n_ie, n_send, n_fin, n_skip, n_clr;
        logic [7:0] n_kbuf, n_tbuf, n_din;
        kb_hit = iot_req && (iot_dev == KB);
        tp_hit = iot_req && (iot_dev == TP);
        idle   = !m_sending && !m_finishing;
        start  = 0;
        n_kbf = m_kbf; n_tpf = m_tpf; n_ie = m_ie; n_kbuf = m_kbuf; n_tbuf = m_tbuf;
        n_send = m_sending; n_fin = 0; n_skip = 0; n_clr = 0; n_din = 8'h00;
        if (kb_hit) begin
            case (iot_fn)
                3'd0: n_kbf = 0;
                3'd1: n_skip = m_kbf;
                3'd2: begin n_kbf = 0; n_clr = 1; end
                3'd4: n_din = m_kbuf;
                3'd5: n_ie = dataout[0];
                3'd6: begin n_kbf = 0; n_clr = 1; n_din = m_kbuf; end
                default: ;
            endcase
        end
        if (kb_valid && !m_kbf) begin
            n_kbuf = kb_data;
            n_kbf  = 1;
        end
        if (tp_hit) begin
            case (iot_fn)
                3'd0: n_tpf = 1;
                3'd1: n_skip = m_tpf;
                3'd2: n_tpf = 0;
                3'd4: start = idle;
                3'd5: n_skip = m_tpf || m_kbf;
                3'd6: begin n_tpf = 0; start = idle; end
                default: ;
            endcase
        end
        if (m_finishing) n_tpf = 1;
        if (m_sending && tp_ready) begin
            n_send = 0;
            n_fin  = 1;
        end
        if (start) begin
            n_tbuf = dataout;
            n_send = 1;
        end
        m_irq = m_ie && (m_kbf || m_tpf);
        m_ack = kb_hit || tp_hit; m_skip = n_skip; m_clr = n_clr; m_din = n_din;
        m_kbf = n_kbf; m_tpf = n_tpf; m_ie = n_ie; m_kbuf = n_kbuf; m_tbuf = n_tbuf;
        m_sending = n_send; m_finishing = n_fin;
    endtask

    task automatic check_all();
        check_eq("iot_ack", iot_ack, m_ack);
        check_eq("datain", datain, m_din);
        check_eq("skip", skip, m_skip);
        check_eq("clr_ac", clr_ac, m_clr);
        check_eq("int_req", int_req, m_irq);
        check_eq("kb_ready", kb_ready, !m_kbf);
        check_eq("tp_valid", tp_valid, m_sending);
        if (m_sending) check_eq("tp_data", tp_data, m_tbuf);
    endtask

    task automatic cycle();
        model_step();
        if (tp_valid && tp_ready) n_xfer++;
        @(posedge clock);
        #1;
        check_all();
    endtask

    task automatic strobe(input logic [5:0] dev, input logic [2:0] fn, input logic [7:0] d);
        iot_req = 1'b1; iot_dev = dev; iot_fn = fn; dataout = d;
        cycle();
        iot_req = 1'b0;
    endtask

    initial begin
        model_reset();
        #12;
        check_all();
        check_eq("rst_tp_data", tp_data, 8'h00);
        @(posedge clock);
        #1;
        reset = 1'b0;
        check_eq("rst_kb_ready", kb_ready, 1'b1);

        strobe(KB, FN_KSF, 8'h00);
        check_eq("ksf_ack", iot_ack, 1'b1);
        check_eq("ksf_skip0", skip, 1'b0);

        kb_valid = 1'b1; kb_data = 8'h41;
        cycle();
        kb_valid = 1'b0;
        strobe(KB, FN_KRB, 8'h00);
        check_eq("krb_datain", datain, 8'h41);
        check_eq("krb_clr_ac", clr_ac, 1'b1);
        strobe(KB, FN_KSF, 8'h00);
        check_eq("ksf_after_krb", skip, 1'b0);

        tp_ready = 1'b0;
        strobe(TP, FN_TLS, 8'h5A);
        check_eq("tls_valid", tp_valid, 1'b1);
        check_eq("tls_data", tp_data, 8'h5A);
        strobe(TP, FN_TSF, 8'h00);
        check_eq("tsf_in_send", skip, 1'b0);
        strobe(TP, FN_TPC, 8'h33);
        check_eq("tpc_busy_data", tp_data, 8'h5A);
        tp_ready = 1'b1;
        cycle();
        tp_ready = 1'b0;
        cycle();
        strobe(TP, FN_TSF, 8'h00);
        check_eq("tsf_after_done", skip, 1'b1);
        tp_ready = 1'b1;
        repeat (4) cycle();
        tp_ready = 1'b0;
        check_eq("single_xfer", n_xfer, 1);

        strobe(TP, FN_TCF, 8'h00);
        strobe(KB, FN_KIE, 8'h01);
        kb_valid = 1'b1; kb_data = 8'h7E;
        cycle();
        kb_valid = 1'b0;
        check_eq("irq_n1", int_req, 1'b0);
        cycle();
        check_eq("irq_n2", int_req, 1'b1);
        strobe(KB, FN_KCF, 8'h00);
        cycle();
        check_eq("irq_after_kcf", int_req, 1'b0);

        strobe(6'o10, FN_TPC, 8'h11);
        check_eq("bad_dev_ack", iot_ack, 1'b0);

        strobe(TP, FN_TLS, 8'hA5);
        check_eq("pre_rst_valid", tp_valid, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check_eq("async_rst_valid", tp_valid, 1'b0);
        model_reset();
        check_all();
        @(posedge clock);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            iot_req = ($urandom_range(0, 9) < 6);
            case ($urandom_range(0, 2))
                0: iot_dev = KB;
                1: iot_dev = TP;
                default: iot_dev = 6'($urandom);
            endcase
            iot_fn   = 3'($urandom);
            dataout  = 8'($urandom);
            kb_valid = ($urandom_range(0, 3) == 0);
            kb_data  = 8'($urandom);
            tp_ready = ($urandom_range(0, 2) != 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
